// File: rtl/bcci_streamer_pkg.sv
// Shared definitions for the BCCI image streamer.
//   state_t     : controller states (configure, await response, stream, await IP done)
//   RESP_*      : AXI write-response encodings
package bcci_streamer_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CFG       = 3'd1,
    S_RESP      = 3'd2,
    S_STREAM    = 3'd3,
    S_WAIT_DONE = 3'd4
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/bcci_stream_skid.sv
// Two-entry FIFO between the frame-memory read pipeline and the AXI4-Stream
// output. Each entry is {pixel, tlast, user}.
//   clk, rst_n  : clock, synchronous active-low reset
//   flush       : empties the FIFO (start of a new frame)
//   push, push_data : write one entry (caller guarantees not full)
//   pop         : remove the head entry (caller guarantees not empty)
//   count       : occupancy 0..2
//   head        : current head entry, meaningful while count != 0
module bcci_stream_skid #(
  parameter int DATA_W = 26
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [1:0]        count,
  output logic [DATA_W-1:0] head
);

  logic [DATA_W-1:0] slot [2];
  logic              wr_ptr;
  logic              rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Payload storage carries no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (push) slot[wr_ptr] <= push_data;
  end

  assign head = slot[rd_ptr];

endmodule

// File: rtl/bcci_img_streamer.sv
// Host-side driver for the BCCI upsampling IP: writes START_VALUE to the IP
// control register over AXI4-Lite, streams one raster-order frame from a
// frame-memory read port over AXI4-Stream, then waits for interrupt_updone.
//   clk, rst_n            : clock, synchronous active-low reset
//   start/busy/done/err   : command and status (err sticky until next start)
//   mem_rd_*              : frame-memory read port, data one cycle after enable
//   m_axi_aw*/w*/b*       : AXI4-Lite write master
//   m_axis_*              : AXI4-Stream master (user marks pixel (0,0))
//   interrupt_updone      : IP completion, level or pulse
module bcci_img_streamer
  import bcci_streamer_pkg::*;
#(
  parameter int                          AXI_DATA_WIDTH    = 32,
  parameter int                          AXI_ADDR_WIDTH    = 32,
  parameter int                          AXISIN_DATA_WIDTH = 24,
  parameter int                          SRC_IMG_WIDTH     = 960,
  parameter int                          SRC_IMG_HEIGHT    = 540,
  parameter int                          MEM_ADDR_WIDTH    = 20,
  parameter logic [AXI_ADDR_WIDTH-1:0]   CTRL_ADDR         = '0,
  parameter logic [AXI_DATA_WIDTH-1:0]   START_VALUE       = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic                           err,
  output logic                           mem_rd_en,
  output logic [MEM_ADDR_WIDTH-1:0]      mem_rd_addr,
  input  logic [AXISIN_DATA_WIDTH-1:0]   mem_rd_data,
  output logic                           m_axi_awvalid,
  output logic [AXI_ADDR_WIDTH-1:0]      m_axi_awaddr,
  output logic [2:0]                     m_axi_awprot,
  input  logic                           m_axi_awready,
  output logic                           m_axi_wvalid,
  output logic [AXI_DATA_WIDTH-1:0]      m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]    m_axi_wstrb,
  input  logic                           m_axi_wready,
  input  logic                           m_axi_bvalid,
  input  logic [1:0]                     m_axi_bresp,
  output logic                           m_axi_bready,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic [AXISIN_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [AXISIN_DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic [AXISIN_DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic                           m_axis_tlast,
  output logic                           m_axis_tid,
  output logic                           m_axis_tdest,
  output logic                           m_axis_user,
  input  logic                           interrupt_updone
);

  localparam int NPIX   = SRC_IMG_WIDTH * SRC_IMG_HEIGHT;
  localparam int COL_W  = (SRC_IMG_WIDTH > 1) ? $clog2(SRC_IMG_WIDTH) : 1;
  localparam int SKID_W = AXISIN_DATA_WIDTH + 2;
  localparam int KEEP_W = AXISIN_DATA_WIDTH / 8;
  localparam int STRB_W = AXI_DATA_WIDTH / 8;

  state_t                      state;
  logic                        irq_seen;
  logic                        start_acc;

  logic [MEM_ADDR_WIDTH-1:0]   rd_addr;
  logic [COL_W-1:0]            rd_col;
  logic                        rd_all;
  logic                        rd_issue;
  logic [MEM_ADDR_WIDTH-1:0]   tx_cnt;
  logic                        tx_last;

  logic                        rd_vld_p1;
  logic                        last_p1;
  logic                        user_p1;

  logic [1:0]                  skid_count;
  logic [SKID_W-1:0]           skid_head;
  logic                        skid_pop;
  logic [2:0]                  occ;

  assign start_acc = (state == S_IDLE) && start;

  // Occupancy as it will stand after this cycle's pop, so a read can be issued
  // in the same cycle a beat leaves and the stream sustains one pixel per cycle.
  assign occ      = {1'b0, skid_count} + {2'b00, rd_vld_p1} - {2'b00, skid_pop};
  assign rd_issue = (state == S_STREAM) && !rd_all && (occ < 3'd2);
  assign tx_last  = (tx_cnt == MEM_ADDR_WIDTH'(NPIX - 1));

  assign mem_rd_en   = rd_issue;
  assign mem_rd_addr = rd_addr;

  // ---- stage p0: read issue, raster address counters ----
  always_ff @(posedge clk) begin
    if (!rst_n || start_acc) begin
      rd_addr <= '0;
      rd_col  <= '0;
      rd_all  <= 1'b0;
      tx_cnt  <= '0;
    end else begin
      if (rd_issue) begin
        rd_addr <= rd_addr + 1'b1;
        rd_col  <= (rd_col == COL_W'(SRC_IMG_WIDTH - 1)) ? '0 : rd_col + 1'b1;
        if (rd_addr == MEM_ADDR_WIDTH'(NPIX - 1)) rd_all <= 1'b1;
      end
      if (skid_pop) tx_cnt <= tx_cnt + 1'b1;
    end
  end

  // ---- stage p1: memory data returns, sideband travels alongside ----
  always_ff @(posedge clk) begin
    if (!rst_n) rd_vld_p1 <= 1'b0;
    else        rd_vld_p1 <= rd_issue;
  end

  always_ff @(posedge clk) begin
    last_p1 <= (rd_col == COL_W'(SRC_IMG_WIDTH - 1));
    user_p1 <= (rd_addr == '0);
  end

  bcci_stream_skid #(
    .DATA_W (SKID_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (start_acc),
    .push      (rd_vld_p1),
    .push_data ({mem_rd_data, last_p1, user_p1}),
    .pop       (skid_pop),
    .count     (skid_count),
    .head      (skid_head)
  );

  // ---- stage p2: skid head drives the stream ----
  // Payload is gated by tvalid so every stream output reads 0 while idle.
  assign m_axis_tvalid = (skid_count != 2'd0);
  assign skid_pop      = m_axis_tvalid && m_axis_tready;
  assign m_axis_tdata  = m_axis_tvalid ? skid_head[SKID_W-1:2] : '0;
  assign m_axis_tlast  = m_axis_tvalid && skid_head[1];
  assign m_axis_user   = m_axis_tvalid && skid_head[0];
  assign m_axis_tkeep  = {KEEP_W{m_axis_tvalid}};
  assign m_axis_tstrb  = {KEEP_W{m_axis_tvalid}};
  assign m_axis_tid    = 1'b0;
  assign m_axis_tdest  = 1'b0;

  assign m_axi_awaddr  = m_axi_awvalid ? CTRL_ADDR : '0;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_wdata   = m_axi_wvalid ? START_VALUE : '0;
  assign m_axi_wstrb   = {STRB_W{m_axi_wvalid}};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      irq_seen      <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state         <= S_CFG;
            busy          <= 1'b1;
            err           <= 1'b0;
            irq_seen      <= 1'b0;
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid  <= 1'b1;
          end
        end
        S_CFG: begin
          if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
          // A channel counts as complete if it already finished or finishes now.
          if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
            state        <= S_RESP;
            m_axi_bready <= 1'b1;
          end
        end
        S_RESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            if (m_axi_bresp == RESP_OKAY) begin
              state <= S_STREAM;
            end else begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
        end
        S_STREAM: begin
          // The IP may finish (and pulse) before our last beat leaves.
          if (interrupt_updone) irq_seen <= 1'b1;
          if (skid_pop && tx_last) state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (interrupt_updone || irq_seen) begin
            done     <= 1'b1;
            busy     <= 1'b0;
            irq_seen <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
